// File: rtl/sbus_pkg.sv
`default_nettype none
// sbus_pkg -- shared SBUS frame constants, state encodings and helpers. Rev 1.0
package sbus_pkg;

  localparam logic [7:0] SBUS_HDR        = 8'h0F;
  localparam logic [7:0] SBUS_FOOT       = 8'h00;
  localparam int         SBUS_NCH        = 16;
  localparam int         SBUS_CHW        = 11;
  localparam int         SBUS_DATA_BYTES = 22;
  localparam int         SBUS_FLAT_W     = SBUS_NCH * SBUS_CHW;

  typedef enum logic [2:0] {
    S_HUNT  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_FLAGS = 3'd3,
    S_FOOT  = 3'd4
  } frame_state_t;

  typedef enum logic [1:0] {
    U_IDLE  = 2'd0,
    U_START = 2'd1,
    U_BITS  = 2'd2
  } uart_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sbus_uart_rx.sv
`default_nettype none
// sbus_uart_rx -- 8E2 byte receiver with input synchroniser and idle-gap detect. Rev 1.0
module sbus_uart_rx
  import sbus_pkg::*;
#(
  parameter int DIV      = 500,
  parameter int GAP_BITS = 20
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_pin,
  input  logic       invert,
  input  logic       en,
  output logic       byte_vld,
  output logic [7:0] rx_byte,
  output logic       par_err,
  output logic       stop_err,
  output logic       gap
);

  localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(DIV / 2 - 1);
  localparam logic [7:0]  GAP_LIM = 8'(GAP_BITS);

  logic        sync1, sync2, rx_d, rx;
  uart_state_t st;
  logic [15:0] cnt;
  logic [3:0]  bit_idx;
  logic [9:0]  sh;
  logic [15:0] idle_tmr;
  logic [7:0]  idle_cnt;

  assign rx  = sync2 ^ invert;
  assign gap = (idle_cnt == GAP_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      rx_d     <= 1'b0;
      st       <= U_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      sh       <= '0;
      idle_tmr <= '0;
      idle_cnt <= '0;
      byte_vld <= 1'b0;
      rx_byte  <= '0;
      par_err  <= 1'b0;
      stop_err <= 1'b0;
    end else begin
      sync1    <= rx_pin;
      sync2    <= sync1;
      rx_d     <= rx;
      byte_vld <= 1'b0;
      if (!en) begin
        st       <= U_IDLE;
        idle_tmr <= '0;
        idle_cnt <= '0;
      end else begin
        case (st)
          U_IDLE: begin
            if (rx_d && !rx) begin
              st       <= U_START;
              cnt      <= HALF_M1;
              idle_tmr <= '0;
              idle_cnt <= '0;
            end else if (!rx) begin
              // A held-low line is not idle, so it restarts the gap count.
              idle_tmr <= '0;
              idle_cnt <= '0;
            end else if (idle_tmr == DIV_M1) begin
              idle_tmr <= '0;
              if (idle_cnt != GAP_LIM) idle_cnt <= idle_cnt + 8'd1;
            end else begin
              idle_tmr <= idle_tmr + 16'd1;
            end
          end
          U_START: begin
            if (cnt != 16'd0) begin
              cnt <= cnt - 16'd1;
            end else if (rx) begin
              st <= U_IDLE;
            end else begin
              st      <= U_BITS;
              cnt     <= DIV_M1;
              bit_idx <= '0;
            end
          end
          U_BITS: begin
            if (cnt != 16'd0) begin
              cnt <= cnt - 16'd1;
            end else if (bit_idx == 4'd10) begin
              // sh holds {stop1, parity, d7..d0}; rx is the second stop bit.
              rx_byte  <= sh[7:0];
              par_err  <= ^sh[8:0];
              stop_err <= !sh[9] || !rx;
              byte_vld <= 1'b1;
              st       <= U_IDLE;
            end else begin
              sh      <= {rx, sh[9:1]};
              bit_idx <= bit_idx + 4'd1;
              cnt     <= DIV_M1;
            end
          end
          default: st <= U_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sbus_frame_rx.sv
`default_nettype none
// sbus_frame_rx -- SBUS 25-byte frame decoder feeding the channel PIOs. Rev 1.0
// Optional link watchdog built when SBUS_FRAME_RX_WDOG_EN is defined.
module sbus_frame_rx
  import sbus_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BAUD     = 100_000,
  parameter int GAP_BITS = 20,
  parameter int WDOG_MS  = 100
)(
  input  logic         clk_clk,
  input  logic         reset_reset_n,
  input  logic         sbus_rx,
  input  logic [15:0]  cfg,
  output logic [175:0] ch_flat,
  output logic [3:0]   flags,
  output logic         frame_valid,
  output logic [7:0]   err_cnt,
  output logic         link_lost
);

  localparam int         DIV      = CLK_HZ / BAUD;
  localparam logic [4:0] LAST_IDX = 5'(SBUS_DATA_BYTES - 1);

  logic       en;
  logic       byte_vld, par_err, stop_err, gap;
  logic [7:0] rx_byte;
  logic       unused_cfg;

  assign en         = cfg[0];
  assign unused_cfg = ^cfg[15:2];

  sbus_uart_rx #(
    .DIV      (DIV),
    .GAP_BITS (GAP_BITS)
  ) u_uart (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .rx_pin   (sbus_rx),
    .invert   (cfg[1]),
    .en       (en),
    .byte_vld (byte_vld),
    .rx_byte  (rx_byte),
    .par_err  (par_err),
    .stop_err (stop_err),
    .gap      (gap)
  );

  frame_state_t           state;
  logic [4:0]             idx;
  logic [SBUS_FLAT_W-1:0] shadow;
  logic [3:0]             flag_nib;
  logic [3:0]             flags_r;
  logic                   byte_ok, commit;

  assign byte_ok = byte_vld && !par_err && !stop_err;
  assign commit  = en && (state == S_FOOT) && !gap && byte_ok && (rx_byte == SBUS_FOOT);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state       <= S_HUNT;
      idx         <= '0;
      shadow      <= '0;
      flag_nib    <= '0;
      ch_flat     <= '0;
      flags_r     <= '0;
      frame_valid <= 1'b0;
      err_cnt     <= '0;
    end else begin
      frame_valid <= 1'b0;
      if (!en) begin
        state <= S_HUNT;
      end else begin
        case (state)
          S_HUNT: if (gap) state <= S_HDR;
          S_HDR: begin
            if (byte_vld) begin
              idx   <= '0;
              state <= (byte_ok && rx_byte == SBUS_HDR) ? S_DATA : S_HUNT;
            end
          end
          S_DATA: begin
            if (gap || (byte_vld && !byte_ok)) begin
              state   <= S_HUNT;
              err_cnt <= sat_inc8(err_cnt);
            end else if (byte_vld) begin
              shadow[{idx, 3'b000} +: 8] <= rx_byte;
              idx <= idx + 5'd1;
              if (idx == LAST_IDX) state <= S_FLAGS;
            end
          end
          S_FLAGS: begin
            if (gap || (byte_vld && !byte_ok)) begin
              state   <= S_HUNT;
              err_cnt <= sat_inc8(err_cnt);
            end else if (byte_vld) begin
              flag_nib <= rx_byte[3:0];
              state    <= S_FOOT;
            end
          end
          S_FOOT: begin
            // Frames may arrive back-to-back, so a good footer re-arms on HDR.
            if (commit) begin
              ch_flat     <= shadow;
              flags_r     <= flag_nib;
              frame_valid <= 1'b1;
              state       <= S_HDR;
            end else if (gap || byte_vld) begin
              state   <= S_HUNT;
              err_cnt <= sat_inc8(err_cnt);
            end
          end
          default: state <= S_HUNT;
        endcase
      end
    end
  end

`ifdef SBUS_FRAME_RX_WDOG_EN
  localparam int          MS_DIV   = CLK_HZ / 1000;
  localparam logic [15:0] WDOG_LIM = 16'(WDOG_MS);

  logic [31:0] ms_pre;
  logic [15:0] ms_cnt;
  logic        lost_r, fs_force;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ms_pre   <= '0;
      ms_cnt   <= '0;
      lost_r   <= 1'b1;
      fs_force <= 1'b0;
    end else if (commit) begin
      ms_pre   <= '0;
      ms_cnt   <= '0;
      lost_r   <= 1'b0;
      fs_force <= 1'b0;
    end else if (ms_cnt == WDOG_LIM) begin
      lost_r   <= 1'b1;
      fs_force <= 1'b1;
    end else if (ms_pre == 32'(MS_DIV - 1)) begin
      ms_pre <= '0;
      ms_cnt <= ms_cnt + 16'd1;
    end else begin
      ms_pre <= ms_pre + 32'd1;
    end
  end

  assign link_lost = lost_r;
  assign flags     = {flags_r[3] | fs_force, flags_r[2:0]};
`else
  logic unused_wdog;
  assign unused_wdog = (WDOG_MS > 0);
  assign link_lost   = 1'b0;
  assign flags       = flags_r;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sbus_frame_rx.sv
`default_nettype none
// tb_sbus_frame_rx -- table-driven frame bench for sbus_frame_rx. Rev 1.0
module tb_sbus_frame_rx;

  localparam int CLK_HZ   = 1_000_000;
  localparam int BAUD     = 62_500;
  localparam int DIV      = CLK_HZ / BAUD;
  localparam int GAP_BITS = 4;
  localparam int WDOG_MS  = 1;
`ifdef SBUS_FRAME_RX_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sbus_rx;
  logic [15:0]  cfg;
  logic [175:0] ch_flat;
  logic [3:0]   flags;
  logic         frame_valid;
  logic [7:0]   err_cnt;
  logic         link_lost;

  always #5 clk = ~clk;

  sbus_frame_rx #(
    .CLK_HZ   (CLK_HZ),
    .BAUD     (BAUD),
    .GAP_BITS (GAP_BITS),
    .WDOG_MS  (WDOG_MS)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .sbus_rx       (sbus_rx),
    .cfg           (cfg),
    .ch_flat       (ch_flat),
    .flags         (flags),
    .frame_valid   (frame_valid),
    .err_cnt       (err_cnt),
    .link_lost     (link_lost)
  );

  typedef struct {
    logic [175:0] flat;
    logic [7:0]   flagb;
    logic [7:0]   foot;
    int           bad;     // frame byte number whose parity is flipped (0 = none)
    int           cut;     // stop after this many data bytes (0 = full frame)
    int           pause;   // 3-bit idle after this data byte (0 = none)
    bit           commit;
    logic [7:0]   err;
  } vec_t;

  vec_t vecs[7];
  int   passed = 0;
  int   total  = 0;
  int   pulses = 0;
  int   cyc    = 0;
  int   last_commit = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (frame_valid) begin
      pulses      = pulses + 1;
      last_commit = cyc;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [175:0] act, input logic [175:0] exp);
    total = total + 1;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else passed = passed + 1;
  endtask

  task automatic send_bit(input logic b);
    sbus_rx = ~b;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(^b ^ flip);
    send_bit(1'b1);
    send_bit(1'b1);
  endtask

  task automatic send_frame(input vec_t v);
    send_byte(8'h0F, 1'b0);
    for (int k = 0; k < 22; k++) begin
      if (v.cut != 0 && k == v.cut) return;
      send_byte(v.flat[8*k +: 8], (v.bad == k + 1));
      if (v.bad == k + 1) return;
      if (v.pause != 0 && k == v.pause) send_idle(3);
    end
    send_byte(v.flagb, 1'b0);
    send_byte(v.foot, 1'b0);
  endtask

  function automatic logic [175:0] pack(input logic [10:0] base, input logic [10:0] step);
    logic [175:0] f = '0;
    for (int n = 0; n < 16; n++) f[11*n +: 11] = base + step * 11'(n);
    return f;
  endfunction

  initial begin
    logic [175:0] exp_flat;
    logic [3:0]   exp_flags;
    logic [3:0]   exp_fl;
    int           p0;
    logic [175:0] pat_a, pat_b;

    pat_a = pack(11'h123, 11'h07D);
    pat_b = pack(11'h7FF, 11'h1F3);
    vecs[0] = '{pack(11'h400, 11'h000), 8'h00, 8'h00, 0, 0, 0, 1'b1, 8'd0};
    vecs[1] = '{176'h7FF,               8'h03, 8'h00, 0, 0, 0, 1'b1, 8'd0};
    vecs[2] = '{pat_a,                  8'h0C, 8'h00, 5, 0, 0, 1'b0, 8'd1};
    vecs[3] = '{pat_a,                  8'h0C, 8'h00, 0, 0, 0, 1'b1, 8'd1};
    vecs[4] = '{pat_b,                  8'h05, 8'h04, 0, 0, 0, 1'b0, 8'd2};
    vecs[5] = '{pat_b,                  8'h05, 8'h00, 0, 2, 0, 1'b0, 8'd3};
    vecs[6] = '{pat_b,                  8'h05, 8'h00, 0, 0, 10, 1'b1, 8'd3};

    sbus_rx = 1'b0;
    cfg     = 16'h0003;
    rst_n   = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ch_flat", ch_flat, 176'd0);
    chk("rst_flags", 176'(flags), 176'd0);
    chk("rst_frame_valid", 176'(frame_valid), 176'd0);
    chk("rst_err_cnt", 176'(err_cnt), 176'd0);
    chk("rst_link_lost", 176'(link_lost), 176'(WDOG));

    exp_flat  = '0;
    exp_flags = '0;
    send_idle(GAP_BITS + 2);

    for (int i = 0; i < 7; i++) begin
      p0 = pulses;
      send_frame(vecs[i]);
      send_idle(GAP_BITS + 2);
      if (vecs[i].commit) begin
        exp_flat  = vecs[i].flat;
        exp_flags = vecs[i].flagb[3:0];
      end
      exp_fl = exp_flags | ((WDOG && !vecs[i].commit) ? 4'h8 : 4'h0);
      chk($sformatf("v%0d_pulses", i), 176'(pulses - p0), 176'(vecs[i].commit));
      chk($sformatf("v%0d_ch_flat", i), ch_flat, exp_flat);
      chk($sformatf("v%0d_flags", i), 176'(flags), 176'(exp_fl));
      chk($sformatf("v%0d_err_cnt", i), 176'(err_cnt), 176'(vecs[i].err));
      chk($sformatf("v%0d_link_lost", i), 176'(link_lost), 176'(WDOG && !vecs[i].commit));
    end

`ifdef SBUS_FRAME_RX_WDOG_EN
    while (cyc < last_commit + 980) @(negedge clk);
    chk("wdog_before_1ms", 176'(link_lost), 176'd0);
    while (cyc < last_commit + 1030) @(negedge clk);
    chk("wdog_after_1ms", 176'(link_lost), 176'd1);
    chk("wdog_failsafe", 176'(flags[3]), 176'd1);
`endif

    // Header followed by a gap in DATA: the cheapest frame that counts as discarded.
    p0 = pulses;
    for (int i = 0; i < 251; i++) begin
      send_byte(8'h0F, 1'b0);
      send_idle(GAP_BITS);
    end
    chk("sat_err_254", 176'(err_cnt), 176'd254);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h0F, 1'b0);
      send_idle(GAP_BITS);
    end
    chk("sat_err_255", 176'(err_cnt), 176'd255);
    chk("sat_ch_flat", ch_flat, exp_flat);
    chk("sat_pulses", 176'(pulses - p0), 176'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
